muldiv_unit: RTL

Iterative multiply/divide sequencer that owns the HI/LO register pair. It executes mult, multu, div and divu as multi-cycle operations, one bit per cycle. While an operation is in flight it raises `busy` and `stall` so the pipeline holds mfhi/mflo and any new HI/LO-writing instruction. It sits beside the ALU in the execute stage and replaces single-cycle HI/LO writes.

---
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative 1-bit/cycle mult/multu/div/divu owning HI/LO
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            rd_hi,
  input  logic            rd_lo,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            stall,
  output logic            done
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                is_div_q, is_div_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic                dz_q, dz_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic                done_q, done_d;

  logic                signed_op;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       rem_sh;
  logic [XLEN:0]       rem_sub;
  logic                rem_ge;
  logic [2*XLEN-1:0]   prod_neg;

  // Datapath helpers: mul_sum keeps the carry, rem_sh holds the shifted remainder
  always_comb begin
    signed_op = ~op[0];
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[cnt_q] ? {1'b0, a_q} : '0);
    rem_sh    = {acc_q[2*XLEN-1:XLEN], a_q[~cnt_q]};
    rem_ge    = (rem_sh >= {1'b0, b_q});
    rem_sub   = rem_sh - {1'b0, b_q};
    prod_neg  = -acc_q;
  end

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_div_d  = op[1];
          a_d       = (signed_op && rs_val[XLEN-1]) ? -rs_val : rs_val;
          b_d       = (signed_op && rt_val[XLEN-1]) ? -rt_val : rt_val;
          neg_quo_d = signed_op & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
          neg_rem_d = signed_op & rs_val[XLEN-1];
          acc_d     = '0;
          cnt_d     = '0;
          if (op[1] && (rt_val == '0)) begin
            // Divide-by-zero keeps the raw dividend for HI
            a_d     = rs_val;
            dz_d    = 1'b1;
            state_d = ST_FIX;
          end else begin
            dz_d    = 1'b0;
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          if (rem_ge) begin
            acc_d = {rem_sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        if (dz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else if (is_div_q) begin
          lo_d = neg_quo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
          hi_d = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        end else begin
          {hi_d, lo_d} = neg_quo_q ? prod_neg : acc_q;
        end
        dz_d    = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      is_div_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;
  assign busy  = (state_q != ST_IDLE);
  assign stall = busy & (rd_hi | rd_lo | start);

endmodule

`default_nettype wire
